add_issue_arbiter: RTL and testbench

- Shares the single pipelined 32-bit adder between NREQ requesters, typically the VLIW issue slots.
- Each cycle, round-robin arbitration picks at most one operand pair, registers it into the adder and tags it with the requester index.
- The tag travels through a shift register matched to the adder latency, so each sum and carry-out is routed back to its originator.

---
 rtl/add_issue_arbiter.sv | 85 ++++++++
 tb/tb_add_issue_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/add_issue_arbiter.sv
// add_issue_arbiter: round-robin issue of operand pairs into one shared pipelined 32-bit adder, with tagged response routing.
// Define ADD_ARB_PERF_EN to add per-requester grant counters and a busy-cycle counter.
module add_issue_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 3,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic                 hold,
  output logic [31:0]          adder_a,
  output logic [31:0]          adder_b,
  input  logic [31:0]          adder_sum,
  input  logic                 adder_cout,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_cout
`ifdef ADD_ARB_PERF_EN
  ,
  output logic [NREQ*16-1:0]   grant_cnt,
  output logic [15:0]          busy_cnt
`endif
);
  logic [IDW-1:0]             r_ptr;
  logic [IDW-1:0]             w_gid;
  logic                       w_fire;
  logic [NREQ-1:0]            w_grant;
  logic [ADD_LAT:0]           r_tv;
  logic [ADD_LAT:0][IDW-1:0]  r_tid;
  // Scan from farthest to nearest after ptr so the nearest valid requester wins.
  always_comb begin
    w_gid  = '0;
    w_fire = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (!hold && req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_gid  = IDW'((int'(r_ptr) + k) % NREQ);
        w_fire = 1'b1;
      end
    end
    w_grant = w_fire ? NREQ'(1) << w_gid : '0;
  end
  assign req_ready = w_grant;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adder_a   <= '0;
      adder_b   <= '0;
      r_ptr     <= IDW'(NREQ - 1);
      r_tv      <= '0;
      r_tid     <= '0;
      rsp_valid <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      if (w_fire) begin
        adder_a <= req_a[32*int'(w_gid) +: 32];
        adder_b <= req_b[32*int'(w_gid) +: 32];
        r_ptr   <= w_gid;
      end
      r_tv      <= {r_tv[ADD_LAT-1:0], w_fire};
      r_tid     <= {r_tid[ADD_LAT-1:0], w_gid};
      rsp_valid <= r_tv[ADD_LAT] ? NREQ'(1) << r_tid[ADD_LAT] : '0;
      if (r_tv[ADD_LAT]) begin
        rsp_sum  <= adder_sum;
        rsp_cout <= adder_cout;
      end
    end
  end
`ifdef ADD_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
      busy_cnt  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (w_grant[i] && grant_cnt[16*i +: 16] != 16'hFFFF)
          grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
      if (|r_tv && busy_cnt != 16'hFFFF) busy_cnt <= busy_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_add_issue_arbiter.sv
// tb_add_issue_arbiter: directed bench for add_issue_arbiter with a 3-stage adder model.
module tb_add_issue_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic               hold;
  logic [31:0]        adder_a, adder_b, adder_sum;
  logic               adder_cout;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_sum;
  logic               rsp_cout;
`ifdef ADD_ARB_PERF_EN
  logic [NREQ*16-1:0] grant_cnt;
  logic [15:0]        busy_cnt;
`endif
  add_issue_arbiter #(.NREQ(NREQ), .ADD_LAT(LAT), .IDW(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .hold(hold), .adder_a(adder_a), .adder_b(adder_b),
    .adder_sum(adder_sum), .adder_cout(adder_cout), .rsp_valid(rsp_valid),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef ADD_ARB_PERF_EN
    , .grant_cnt(grant_cnt), .busy_cnt(busy_cnt)
`endif
  );
  always #5 clk = ~clk;
  logic [32:0] p [0:LAT-1];
  always @(posedge clk) begin
    p[0] <= {1'b0, adder_a} + {1'b0, adder_b};
    for (int i = 1; i < LAT; i++) p[i] <= p[i-1];
  end
  assign adder_sum  = p[LAT-1][31:0];
  assign adder_cout = p[LAT-1][32];
  int total = 0;
  int bad = 0;
  logic [NREQ-1:0] e_v [0:31];
  logic [31:0]     e_s [0:31];
  logic            e_c [0:31];
  logic [NREQ-1:0] exp_g;
  task automatic clr_exp();
    for (int i = 0; i < 32; i++) begin
      e_v[i] = '0;
      e_s[i] = '0;
      e_c[i] = 1'b0;
    end
  endtask
  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask
  // Response for a handshake at step s appears at step s+LAT+2.
  task automatic expect_rsp(input int s, input int g);
    logic [32:0] t;
    t = {1'b0, req_a[32*g +: 32]} + {1'b0, req_b[32*g +: 32]};
    e_v[s+LAT+2] = 4'b1 << g;
    e_s[s+LAT+2] = t[31:0];
    e_c[s+LAT+2] = t[32];
  endtask
  task automatic test_reset();
    reset = 1'b0; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (adder_a !== 32'h0) begin bad++; $display("FAIL reset_adder_a got %h want 0", adder_a); end
    total++; if (adder_b !== 32'h0) begin bad++; $display("FAIL reset_adder_b got %h want 0", adder_b); end
    total++; if (rsp_valid !== 4'h0) begin bad++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    total++; if (rsp_sum !== 32'h0 || rsp_cout !== 1'b0) begin bad++; $display("FAIL reset_rsp got sum=%h cout=%b want 0/0", rsp_sum, rsp_cout); end
    req_valid = 4'hF; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_prio got %b want 0001", req_ready); end
    hold = 1'b1; #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_hold got %b want 0000", req_ready); end
    hold = 1'b0; req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_round_robin();
    clr_exp();
    for (int s = 0; s < 15; s++) begin
      @(negedge clk);
      req_valid = s < 8 ? 4'hF : 4'h0;
      for (int i = 0; i < NREQ; i++) set_op(i, 32'((i + 1) << 28) + 32'(s * 256), 32'(s * 7 + i));
      exp_g = s < 8 ? 4'b1 << (s % 4) : 4'b0;
      if (s < 8) expect_rsp(s, s % 4);
      #1;
      total++; if (req_ready !== exp_g) begin bad++; $display("FAIL rr_grant step %0d got %b want %b", s, req_ready, exp_g); end
      total++;
      if (rsp_valid !== e_v[s] || (e_v[s] != 0 && (rsp_sum !== e_s[s] || rsp_cout !== e_c[s]))) begin
        bad++; $display("FAIL rr_rsp step %0d got v=%b sum=%h c=%b want v=%b sum=%h c=%b", s, rsp_valid, rsp_sum, rsp_cout, e_v[s], e_s[s], e_c[s]);
      end
    end
  endtask
  task automatic test_single();
    clr_exp();
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      req_valid = s == 0 ? 4'b0100 : 4'b0000;
      set_op(2, 32'd5, 32'd7);
      exp_g = s == 0 ? 4'b0100 : 4'b0000;
      if (s == 0) begin
        e_v[5] = 4'b0100; e_s[5] = 32'd12; e_c[5] = 1'b0;
      end
      #1;
      total++; if (req_ready !== exp_g) begin bad++; $display("FAIL single_grant step %0d got %b want %b", s, req_ready, exp_g); end
      total++;
      if (rsp_valid !== e_v[s] || (e_v[s] != 0 && (rsp_sum !== e_s[s] || rsp_cout !== e_c[s]))) begin
        bad++; $display("FAIL single_rsp step %0d got v=%b sum=%h c=%b want v=%b sum=%h c=%b", s, rsp_valid, rsp_sum, rsp_cout, e_v[s], e_s[s], e_c[s]);
      end
    end
  endtask
  task automatic test_carry();
    clr_exp();
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      req_valid = s == 0 ? 4'b0010 : 4'b0000;
      set_op(1, 32'hFFFF_FFFF, 32'h0000_0001);
      exp_g = s == 0 ? 4'b0010 : 4'b0000;
      if (s == 0) begin
        e_v[5] = 4'b0010; e_s[5] = 32'h0; e_c[5] = 1'b1;
      end
      #1;
      total++; if (req_ready !== exp_g) begin bad++; $display("FAIL carry_grant step %0d got %b want %b", s, req_ready, exp_g); end
      total++;
      if (rsp_valid !== e_v[s] || (e_v[s] != 0 && (rsp_sum !== e_s[s] || rsp_cout !== e_c[s]))) begin
        bad++; $display("FAIL carry_rsp step %0d got v=%b sum=%h c=%b want v=%b sum=%h c=%b", s, rsp_valid, rsp_sum, rsp_cout, e_v[s], e_s[s], e_c[s]);
      end
    end
  endtask
  task automatic test_hold();
    int g_tab [0:8] = '{2, 3, 0, -1, -1, -1, -1, 1, 2};
    clr_exp();
    for (int s = 0; s < 15; s++) begin
      @(negedge clk);
      hold = s >= 3 && s < 7;
      req_valid = s < 9 ? 4'hF : 4'h0;
      for (int i = 0; i < NREQ; i++) set_op(i, 32'h0A00_0000 + 32'(s * 16 + i), 32'h0000_0100 * 32'(i + 1));
      exp_g = (s < 9 && g_tab[s] >= 0) ? 4'b1 << g_tab[s] : 4'b0;
      if (s < 9 && g_tab[s] >= 0) expect_rsp(s, g_tab[s]);
      #1;
      total++; if (req_ready !== exp_g) begin bad++; $display("FAIL hold_grant step %0d got %b want %b", s, req_ready, exp_g); end
      total++;
      if (rsp_valid !== e_v[s] || (e_v[s] != 0 && (rsp_sum !== e_s[s] || rsp_cout !== e_c[s]))) begin
        bad++; $display("FAIL hold_rsp step %0d got v=%b sum=%h c=%b want v=%b sum=%h c=%b", s, rsp_valid, rsp_sum, rsp_cout, e_v[s], e_s[s], e_c[s]);
      end
    end
    hold = 1'b0;
  endtask
  task automatic test_reset_mid();
    for (int s = 0; s < 13; s++) begin
      @(negedge clk);
      reset = !(s == 2 || s == 3);
      req_valid = (s < 2 || s == 12) ? 4'hF : 4'h0;
      for (int i = 0; i < NREQ; i++) set_op(i, 32'h1234_0000 + 32'(i), 32'h0000_1111);
      exp_g = s == 0 ? 4'b1000 : s == 1 ? 4'b0001 : s == 12 ? 4'b0001 : 4'b0000;
      #1;
      total++; if (req_ready !== exp_g) begin bad++; $display("FAIL rmid_grant step %0d got %b want %b", s, req_ready, exp_g); end
      if (s == 2) begin
        total++;
        if (adder_a !== 32'h0 || adder_b !== 32'h0 || rsp_sum !== 32'h0 || rsp_cout !== 1'b0) begin
          bad++; $display("FAIL rmid_clear got a=%h b=%h sum=%h c=%b want all 0", adder_a, adder_b, rsp_sum, rsp_cout);
        end
      end
      if (s >= 2) begin
        total++; if (rsp_valid !== 4'h0) begin bad++; $display("FAIL rmid_rsp step %0d got %b want 0000", s, rsp_valid); end
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask
`ifdef ADD_ARB_PERF_EN
  task automatic test_perf();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    #1;
    total++; if (grant_cnt !== '0 || busy_cnt !== 16'h0) begin bad++; $display("FAIL perf_clear got g=%h b=%h want 0", grant_cnt, busy_cnt); end
    for (int s = 0; s < 70000; s++) begin
      @(negedge clk);
      req_valid = 4'b1000;
    end
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
    #1;
    total++; if (grant_cnt !== {16'hFFFF, 48'h0}) begin bad++; $display("FAIL perf_grant got %h want ffff000000000000", grant_cnt); end
    total++; if (busy_cnt !== 16'hFFFF) begin bad++; $display("FAIL perf_busy got %h want ffff", busy_cnt); end
  endtask
`endif
  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_carry();
    test_hold();
    test_reset_mid();
`ifdef ADD_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
